processorci_bus_arbiter: RTL and testbench



---
 rtl/processorci_bus_arbiter_pkg.sv | 23 ++
 rtl/processorci_bus_arbiter_if.sv | 47 ++++
 rtl/processorci_bus_arbiter_rr_picker.sv | 26 ++
 rtl/processorci_bus_arbiter.sv | 106 ++++++++++
 tb/tb_processorci_bus_arbiter.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/processorci_bus_arbiter_pkg.sv
// Shared types and defaults for the N-master Wishbone-classic arbiter.
// Optional bus timeout is enabled with PROCESSORCI_ARB_TIMEOUT_EN.
package processorci_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

  localparam int DEF_NUM_MASTERS    = 2;
  localparam int DEF_ADDR_W         = 32;
  localparam int DEF_DATA_W         = 32;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

  // Index width for n channels; one bit minimum so the single-master build stays legal.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/processorci_bus_arbiter_if.sv
// Bundle of master-side and slave-side Wishbone signals around the arbiter.
// slave: the arbiter's view; master: the surrounding core/Controller view.
interface processorci_bus_arbiter_if
  import processorci_arb_pkg::*;
#(
  parameter int NUM_MASTERS = DEF_NUM_MASTERS,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W
);
  localparam int SEL_W = DATA_W / 8;
  localparam int IDX_W = idx_w(NUM_MASTERS);

  logic [NUM_MASTERS-1:0]             m_cyc_i;
  logic [NUM_MASTERS-1:0]             m_stb_i;
  logic [NUM_MASTERS-1:0]             m_we_i;
  logic [NUM_MASTERS-1:0][SEL_W-1:0]  m_wstrb_i;
  logic [NUM_MASTERS-1:0][ADDR_W-1:0] m_addr_i;
  logic [NUM_MASTERS-1:0][DATA_W-1:0] m_data_i;
  logic [DATA_W-1:0]                  m_data_o;
  logic [NUM_MASTERS-1:0]             m_ack_o;
  logic [NUM_MASTERS-1:0]             m_err_o;
  logic [IDX_W-1:0]                   grant_o;

  logic              s_cyc_o;
  logic              s_stb_o;
  logic              s_we_o;
  logic [SEL_W-1:0]  s_wstrb_o;
  logic [ADDR_W-1:0] s_addr_o;
  logic [DATA_W-1:0] s_data_o;
  logic [DATA_W-1:0] s_data_i;
  logic              s_ack_i;

  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_wstrb_i, m_addr_i, m_data_i,
    output m_data_o, m_ack_o, m_err_o, grant_o,
    output s_cyc_o, s_stb_o, s_we_o, s_wstrb_o, s_addr_o, s_data_o,
    input  s_data_i, s_ack_i
  );

  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_wstrb_i, m_addr_i, m_data_i,
    input  m_data_o, m_ack_o, m_err_o, grant_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_wstrb_o, s_addr_o, s_data_o,
    output s_data_i, s_ack_i
  );

endinterface

// File: rtl/processorci_bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester at or after last+1, wrapping.
module rr_picker #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  // Scan distances from farthest to nearest so the nearest requester is written last.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = N; i >= 1; i--) begin
      for (int k = 0; k < N; k++) begin
        if (req[k] && (k == ((int'(last) + i) % N))) begin
          valid = 1'b1;
          idx   = IDX_W'(k);
        end
      end
    end
  end

endmodule

// File: rtl/processorci_bus_arbiter.sv
// N-master to 1-slave Wishbone-classic arbiter, one outstanding transaction per grant.
// Define PROCESSORCI_ARB_TIMEOUT_EN to add the REQ-state timeout with error response.
module processorci_bus_arbiter
  import processorci_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = DEF_NUM_MASTERS,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input logic                     sys_clk,
  input logic                     rst_n,
  processorci_bus_arbiter_if.slave bus
);
  localparam int IDX_W = idx_w(NUM_MASTERS);

  arb_state_e       state;
  logic             aborted;
  logic             pick_vld;
  logic [IDX_W-1:0] pick_idx;
  logic             lost;

  rr_picker #(.N(NUM_MASTERS), .IDX_W(IDX_W)) u_pick (
    .req   (bus.m_cyc_i & bus.m_stb_i),
    .last  (bus.grant_o),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  // A master that let go of cyc at any point of REQ forfeits the response.
  assign lost = aborted | ~bus.m_cyc_i[bus.grant_o];

`ifdef PROCESSORCI_ARB_TIMEOUT_EN
  localparam int                TO_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [DATA_W-1:0] ERR_D   = DATA_W'(ERR_DATA);
  logic [TO_W-1:0] to_cnt;
`endif

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      aborted       <= 1'b0;
      bus.grant_o   <= '0;
      bus.m_data_o  <= '0;
      bus.m_ack_o   <= '0;
      bus.m_err_o   <= '0;
      bus.s_cyc_o   <= 1'b0;
      bus.s_stb_o   <= 1'b0;
      bus.s_we_o    <= 1'b0;
      bus.s_wstrb_o <= '0;
      bus.s_addr_o  <= '0;
      bus.s_data_o  <= '0;
`ifdef PROCESSORCI_ARB_TIMEOUT_EN
      to_cnt        <= '0;
`endif
    end else begin
      bus.m_ack_o <= '0;
      bus.m_err_o <= '0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            bus.s_cyc_o   <= 1'b1;
            bus.s_stb_o   <= 1'b1;
            bus.s_we_o    <= bus.m_we_i[pick_idx];
            bus.s_wstrb_o <= bus.m_wstrb_i[pick_idx];
            bus.s_addr_o  <= bus.m_addr_i[pick_idx];
            bus.s_data_o  <= bus.m_data_i[pick_idx];
            bus.grant_o   <= pick_idx;
            aborted       <= 1'b0;
`ifdef PROCESSORCI_ARB_TIMEOUT_EN
            to_cnt        <= '0;
`endif
            state         <= REQ;
          end
        end
        REQ: begin
          if (!bus.m_cyc_i[bus.grant_o]) aborted <= 1'b1;
          if (bus.s_ack_i) begin
            bus.s_cyc_o <= 1'b0;
            bus.s_stb_o <= 1'b0;
            if (!lost) begin
              bus.m_ack_o <= NUM_MASTERS'(1) << bus.grant_o;
              if (!bus.s_we_o) bus.m_data_o <= bus.s_data_i;
            end
            state <= RESP;
          end
`ifdef PROCESSORCI_ARB_TIMEOUT_EN
          else if (to_cnt == TO_LAST) begin
            bus.s_cyc_o  <= 1'b0;
            bus.s_stb_o  <= 1'b0;
            bus.m_data_o <= ERR_D;
            bus.m_err_o  <= NUM_MASTERS'(1) << bus.grant_o;
            state        <= RESP;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_processorci_bus_arbiter.sv
// Directed plus randomized bench for the arbiter, two masters, reference model in plain arithmetic.
module tb_processorci_bus_arbiter;
  localparam int NM = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic sys_clk = 1'b0;
  logic rst_n   = 1'b0;
  always #5 sys_clk = ~sys_clk;

  processorci_bus_arbiter_if #(.NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW)) bus ();

  processorci_bus_arbiter #(.NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(8)) dut (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  // model state
  int          last  = 0;
  logic [31:0] mdata = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge sys_clk);
  endtask

  task automatic drive(input int k, input logic req, input logic we, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] strb);
    bus.m_cyc_i[k]   = req;
    bus.m_stb_i[k]   = req;
    bus.m_we_i[k]    = we;
    bus.m_addr_i[k]  = addr;
    bus.m_data_i[k]  = data;
    bus.m_wstrb_i[k] = strb;
  endtask

  function automatic int rr_pick(input int mask, input int lst);
    for (int i = 1; i <= NM; i++)
      if (((mask >> ((lst + i) % NM)) & 1) != 0) return (lst + i) % NM;
    return -1;
  endfunction

  initial begin
    int          pulses[$];
    int          pcyc[$];
    int          n;
    int          w;
    int          mask;
    logic        rwe[NM];
    logic [31:0] raddr[NM];
    logic [31:0] rdat[NM];
    logic [3:0]  rstb[NM];
    logic [31:0] sd;

    bus.m_cyc_i = '0; bus.m_stb_i = '0; bus.m_we_i = '0;
    bus.m_wstrb_i = '0; bus.m_addr_i = '0; bus.m_data_i = '0;
    bus.s_ack_i = 1'b0; bus.s_data_i = '0;
    repeat (3) tick();
    chk("rst_cyc", 64'(bus.s_cyc_o), 0);
    chk("rst_stb", 64'(bus.s_stb_o), 0);
    chk("rst_ack", 64'(bus.m_ack_o), 0);
    chk("rst_grant", 64'(bus.grant_o), 0);
    chk("rst_mdata", 64'(bus.m_data_o), 0);
    rst_n = 1'b1;
    tick();

    // single master 0 read
    drive(0, 1, 0, 32'h100, 0, 4'hF);
    tick();
    chk("t1_stb", 64'(bus.s_stb_o), 1);
    chk("t1_addr", 64'(bus.s_addr_o), 32'h100);
    chk("t1_we", 64'(bus.s_we_o), 0);
    chk("t1_grant", 64'(bus.grant_o), 0);
    tick(); tick();
    chk("t1_hold", 64'(bus.s_stb_o), 1);
    bus.s_ack_i = 1; bus.s_data_i = 32'h1234_5678;
    tick();
    chk("t1_ack", 64'(bus.m_ack_o), 2'b01);
    chk("t1_data", 64'(bus.m_data_o), 32'h1234_5678);
    chk("t1_drop", 64'(bus.s_stb_o), 0);
    bus.s_ack_i = 0; drive(0, 0, 0, 0, 0, 0);
    tick();
    chk("t1_pulse1", 64'(bus.m_ack_o), 0);
    last = 0; mdata = 32'h1234_5678;

    // master 1 write
    drive(1, 1, 1, 32'h2000, 32'hCAFE_BABE, 4'h3);
    tick();
    chk("t2_grant", 64'(bus.grant_o), 1);
    chk("t2_sdata", 64'(bus.s_data_o), 32'hCAFE_BABE);
    chk("t2_wstrb", 64'(bus.s_wstrb_o), 4'h3);
    chk("t2_we", 64'(bus.s_we_o), 1);
    bus.s_ack_i = 1; bus.s_data_i = 32'h0BAD_0BAD;
    tick();
    chk("t2_ack", 64'(bus.m_ack_o), 2'b10);
    chk("t2_mdata", 64'(bus.m_data_o), mdata);
    bus.s_ack_i = 0; drive(1, 0, 0, 0, 0, 0);
    tick();
    last = 1;

    // contention, slave acks immediately
    drive(0, 1, 0, 32'h10, 0, 4'hF);
    drive(1, 1, 0, 32'h20, 0, 4'hF);
    bus.s_ack_i = 1; bus.s_data_i = 32'h0BAD_F00D;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (bus.m_ack_o != 0) begin pulses.push_back(int'(bus.m_ack_o)); pcyc.push_back(c); end
    end
    chk("t3_npulse", 64'(pulses.size()), 4);
    for (int i = 0; i < pulses.size() && i < 4; i++) begin
      last = (last + 1) % NM;
      chk("t3_order", 64'(pulses[i]), 64'(1 << last));
      if (i > 0) chk("t3_space", 64'(pcyc[i] - pcyc[i-1]), 3);
    end

    // async reset in REQ
    n = 0;
    while (!bus.s_stb_o && n < 6) begin tick(); n++; end
    chk("t6_inreq", 64'(bus.s_stb_o), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_cyc", 64'(bus.s_cyc_o), 0);
    chk("t6_stb", 64'(bus.s_stb_o), 0);
    chk("t6_grant", 64'(bus.grant_o), 0);
    chk("t6_mdata", 64'(bus.m_data_o), 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6_regrant", 64'(bus.grant_o), 1);
    chk("t6_addr", 64'(bus.s_addr_o), 32'h20);
    // both drop while s_ack is high: completion is discarded
    drive(0, 0, 0, 0, 0, 0); drive(1, 0, 0, 0, 0, 0);
    tick();
    chk("t6_noack", 64'(bus.m_ack_o), 0);
    chk("t6_keep", 64'(bus.m_data_o), 0);
    bus.s_ack_i = 0;
    tick();
    last = 1; mdata = 0;

    // abort by master 0, then pending master 1 served
    drive(0, 1, 0, 32'h300, 0, 4'hF);
    tick();
    chk("t4_grant0", 64'(bus.grant_o), 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 32'h400, 0, 4'hF);
    tick(); tick();
    bus.s_ack_i = 1; bus.s_data_i = 32'h77;
    tick();
    chk("t4_noack", 64'(bus.m_ack_o), 0);
    chk("t4_mdata", 64'(bus.m_data_o), mdata);
    bus.s_ack_i = 0;
    n = 0;
    do begin tick(); n++; end while (!bus.s_stb_o && n < 6);
    chk("t4_grant1", 64'(bus.grant_o), 1);
    chk("t4_addr1", 64'(bus.s_addr_o), 32'h400);
    bus.s_ack_i = 1; bus.s_data_i = 32'h55AA_0001;
    tick();
    chk("t4_ack1", 64'(bus.m_ack_o), 2'b10);
    chk("t4_data1", 64'(bus.m_data_o), 32'h55AA_0001);
    bus.s_ack_i = 0; drive(1, 0, 0, 0, 0, 0);
    tick();
    last = 1; mdata = 32'h55AA_0001;

    // randomized rounds
    for (int r = 0; r < 20; r++) begin
      mask = $urandom_range(1, 3);
      for (int k = 0; k < NM; k++) begin
        rwe[k] = 1'($urandom_range(0, 1)); raddr[k] = $urandom; rdat[k] = $urandom; rstb[k] = 4'($urandom);
        drive(k, ((mask >> k) & 1) != 0, rwe[k], raddr[k], rdat[k], rstb[k]);
      end
      w = rr_pick(mask, last);
      tick();
      chk("rnd_stb", 64'(bus.s_stb_o), 1);
      chk("rnd_grant", 64'(bus.grant_o), 64'(w));
      chk("rnd_addr", 64'(bus.s_addr_o), 64'(raddr[w]));
      chk("rnd_fields", {31'd0, bus.s_we_o, bus.s_wstrb_o, bus.s_data_o}, {31'd0, rwe[w], rstb[w], rdat[w]});
      repeat ($urandom_range(0, 2)) tick();
      sd = $urandom;
      bus.s_ack_i = 1; bus.s_data_i = sd;
      tick();
      if (!rwe[w]) mdata = sd;
      chk("rnd_ack", 64'(bus.m_ack_o), 64'(1 << w));
      chk("rnd_err", 64'(bus.m_err_o), 0);
      chk("rnd_mdata", 64'(bus.m_data_o), 64'(mdata));
      chk("rnd_drop", 64'(bus.s_stb_o), 0);
      bus.s_ack_i = 0;
      for (int k = 0; k < NM; k++) drive(k, 0, 0, 0, 0, 0);
      tick();
      last = w;
    end

`ifdef PROCESSORCI_ARB_TIMEOUT_EN
    // timeout with no ack
    drive(0, 1, 0, 32'h500, 0, 4'hF);
    tick();
    n = bus.s_stb_o ? 1 : 0;
    for (int i = 0; i < 20 && bus.s_stb_o; i++) begin
      tick();
      if (bus.s_stb_o) n++;
    end
    chk("to_len", 64'(n), 8);
    chk("to_err", 64'(bus.m_err_o), 2'b01);
    chk("to_noack", 64'(bus.m_ack_o), 0);
    chk("to_data", 64'(bus.m_data_o), 32'hDEAD_BEEF);
    drive(0, 0, 0, 0, 0, 0);
    tick(); tick();
    // ack on the final REQ cycle wins over the timeout
    drive(0, 1, 0, 32'h600, 0, 4'hF);
    tick();
    for (int i = 1; i < 8; i++) tick();
    chk("to_still", 64'(bus.s_stb_o), 1);
    bus.s_ack_i = 1; bus.s_data_i = 32'h0000_4242;
    tick();
    chk("to_ackwin", 64'(bus.m_ack_o), 2'b01);
    chk("to_noerr", 64'(bus.m_err_o), 0);
    chk("to_ackdata", 64'(bus.m_data_o), 32'h0000_4242);
    bus.s_ack_i = 0; drive(0, 0, 0, 0, 0, 0);
    tick(); tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
